// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - 2-way dcache sequencer: hit service, dirty write-back, refill and replay
module dcache_controller #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 23,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [TAG_W+1:0]  sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic              sram_hit_i,
  input  logic [TAG_W+1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o,
  output logic [CNT_W-1:0]  wb_cnt_o
);

  // Byte offset inside a line, word-select width and bit offset of a word in a line
  localparam int OFF_W  = ADDR_W - TAG_W - IDX_W;
  localparam int WSEL_W = $clog2(LINE_W / WORD_W);
  localparam int BIT_W  = $clog2(LINE_W);

  typedef enum logic [1:0] {IDLE, WRITEBACK, READMISS, REFILL} state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] word_sel;
  logic [BIT_W-1:0]  word_base;

  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_data;
  logic [LINE_W-1:0] refill_data;
  logic              replay;
  logic [LINE_W-1:0] merged;

  logic hit_ev, miss_ev, wb_ev;
  logic unused_addr;

  assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign idx         = cpu_addr_i[OFF_W +: IDX_W];
  assign word_sel    = cpu_addr_i[OFF_W-1 -: WSEL_W];
  assign word_base   = {word_sel, {(BIT_W - WSEL_W){1'b0}}};
  assign unused_addr = ^cpu_addr_i[OFF_W-WSEL_W-1:0];

  // Set index depends only on state and address, never on the lookup result
  assign sram_addr_o = rst_i ? '0 :
                       (state == REFILL) ? miss_idx :
                       (state == IDLE && cpu_req_i) ? idx : '0;

  // Store-hit line: lookup data with the addressed word replaced
  always_comb begin
    merged = sram_data_i;
    merged[word_base +: WORD_W] = cpu_data_i;
  end

  // Next-state and all per-state outputs; reset forces everything quiet
  always_comb begin
    state_next    = state;
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    hit_ev        = 1'b0;
    miss_ev       = 1'b0;
    wb_ev         = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            sram_enable_o = 1'b1;
            sram_tag_o    = {1'b1, 1'b0, tag};
            if (sram_hit_i) begin
              cpu_data_o = sram_data_i[word_base +: WORD_W];
              hit_ev     = !replay;
              if (cpu_write_i) begin
                sram_write_o = 1'b1;
                sram_tag_o   = {1'b1, 1'b1, tag};
                sram_data_o  = merged;
              end
            end else begin
              cpu_stall_o = 1'b1;
              miss_ev     = 1'b1;
              state_next  = (sram_tag_i[TAG_W+1] && sram_tag_i[TAG_W]) ? WRITEBACK : READMISS;
            end
          end
        end
        WRITEBACK: begin
          cpu_stall_o  = cpu_req_i;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {victim_tag, miss_idx, {OFF_W{1'b0}}};
          mem_data_o   = victim_data;
          if (mem_ack_i) begin
            wb_ev      = 1'b1;
            state_next = READMISS;
          end
        end
        READMISS: begin
          cpu_stall_o  = cpu_req_i;
          mem_enable_o = 1'b1;
          mem_addr_o   = {miss_tag, miss_idx, {OFF_W{1'b0}}};
          if (mem_ack_i) state_next = REFILL;
        end
        REFILL: begin
          cpu_stall_o   = cpu_req_i;
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_tag_o    = {1'b1, 1'b0, miss_tag};
          sram_data_o   = refill_data;
          state_next    = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Miss context, victim line and refill line capture
  always_ff @(posedge clk_i) begin
    if (miss_ev) begin
      miss_tag    <= tag;
      miss_idx    <= idx;
      victim_tag  <= sram_tag_i[TAG_W-1:0];
      victim_data <= sram_data_i;
    end
    if (!rst_i && state == READMISS && mem_ack_i) refill_data <= mem_data_i;
  end

  // Replay marker: the first IDLE cycle after a refill is the replayed access
  always_ff @(posedge clk_i) begin
    if (rst_i)                replay <= 1'b0;
    else if (state == REFILL) replay <= 1'b1;
    else if (state == IDLE)   replay <= 1'b0;
  end

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (hit_ev  && hit_cnt_o  != '1) hit_cnt_o  <= hit_cnt_o  + 1'b1;
      if (miss_ev && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
      if (wb_ev   && wb_cnt_o   != '1) wb_cnt_o   <= wb_cnt_o   + 1'b1;
    end
  end

endmodule
